ex_muldiv_ctrl: RTL and testbench

Multi-cycle multiply/divide sequencer beside the EX-stage ALU. It accepts operands already resolved by the EX forwarding muxes and runs a 32-iteration shift-add multiply or restoring divide. It holds the pipeline via `stall` while busy and owns the architectural HI/LO registers, which are read by MFHI/MFLO and written by MTHI/MTLO.

---
 rtl/ex_muldiv_ctrl.sv | 121 ++++++++++++
 tb/tb_ex_muldiv_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_ctrl.sv
// ex_muldiv_ctrl: multi-cycle shift-add multiply / restoring divide sequencer owning HI/LO
// Ports:
//   clk, rst (async, active-low)
//   start/op/operand_a/operand_b : launch MULT(00) MULTU(01) DIV(10) DIVU(11)
//   flush                        : squash the in-flight operation
//   hi_we/lo_we/wdata            : MTHI/MTLO writes, honoured only when not running
//   stall (comb), busy, done, div_by_zero, hi, lo
module ex_muldiv_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t               r_state, w_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_opnd, r_hi, r_lo;
    logic                 r_div, r_sa, r_sb, r_dbz;

    logic                 w_idle, w_accept, w_dz, w_sa, w_sb, w_last;
    logic [WIDTH-1:0]     w_abs_a, w_abs_b;
    logic [WIDTH:0]       w_sum, w_diff;
    logic [2*WIDTH:0]     w_sh;
    logic [2*WIDTH-1:0]   w_mul, w_dvs, w_step, w_prod;
    logic [WIDTH-1:0]     w_quo, w_rem, w_res_hi, w_res_lo;

    assign w_idle   = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_accept = start & ~flush & w_idle;
    assign w_dz     = op[1] & (operand_b == '0);
    assign w_sa     = ~op[0] & operand_a[WIDTH-1];
    assign w_sb     = ~op[0] & operand_b[WIDTH-1];
    assign w_abs_a  = w_sa ? -operand_a : operand_a;
    assign w_abs_b  = w_sb ? -operand_b : operand_b;
    assign w_last   = r_cnt == CNT_W'(WIDTH - 1);

    // multiply: r_acc = {partial product, remaining multiplier bits}
    assign w_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + ({1'b0, r_opnd} & {(WIDTH+1){r_acc[0]}});
    assign w_mul  = {w_sum, r_acc[WIDTH-1:1]};

    // divide: r_acc = {remainder, quotient}; the shifted remainder needs WIDTH+1 bits
    assign w_sh   = {r_acc, 1'b0};
    assign w_diff = w_sh[2*WIDTH:WIDTH] - {1'b0, r_opnd};
    assign w_dvs  = w_diff[WIDTH] ? w_sh[2*WIDTH-1:0] : {w_diff[WIDTH-1:0], w_sh[WIDTH-1:1], 1'b1};
    assign w_step = r_div ? w_dvs : w_mul;

    // sign fix-up; signs are zero for unsigned ops so no op decode is needed here
    assign w_prod   = (r_sa ^ r_sb) ? -r_acc : r_acc;
    assign w_quo    = (r_sa ^ r_sb) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem    = r_sa ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    assign w_res_hi = r_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
    assign w_res_lo = r_div ? w_quo : w_prod[WIDTH-1:0];

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RUN:   w_next = flush ? S_IDLE : (w_last ? S_FIX : S_RUN);
            S_FIX:   w_next = flush ? S_IDLE : S_DONE;
            default: w_next = w_accept ? (w_dz ? S_DONE : S_RUN) : S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_opnd  <= '0;
            r_div   <= 1'b0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_dbz   <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_next;
            r_dbz   <= w_accept & w_dz;
            if (w_accept) begin
                r_cnt  <= '0;
                r_div  <= op[1];
                r_sa   <= w_sa;
                r_sb   <= w_sb;
                r_opnd <= op[1] ? w_abs_b : w_abs_a;
                r_acc  <= {{WIDTH{1'b0}}, op[1] ? w_abs_a : w_abs_b};
            end else if (r_state == S_RUN) begin
                r_cnt <= r_cnt + 1'b1;
                r_acc <= w_step;
            end
            if (r_state == S_FIX && !flush) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end else if (w_idle) begin
                if (hi_we) r_hi <= wdata;
                if (lo_we) r_lo <= wdata;
            end
        end
    end

    assign stall       = w_accept | (r_state == S_RUN) | (r_state == S_FIX);
    assign busy        = (r_state == S_RUN) | (r_state == S_FIX);
    assign done        = r_state == S_DONE;
    assign div_by_zero = r_dbz;
    assign hi          = r_hi;
    assign lo          = r_lo;
endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// tb_ex_muldiv_ctrl: scoreboard bench for the multiply/divide sequencer
module tb_ex_muldiv_ctrl;
    logic        clk = 1'b0;
    logic        rst, start, flush, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] operand_a, operand_b, wdata;
    logic        stall, busy, done, div_by_zero;
    logic [31:0] hi, lo;

    logic [64:0] sb_q[$];
    int          n_chk = 0;
    int          n_fail = 0;

    ex_muldiv_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b), .flush(flush),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .stall(stall), .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic signed [31:0] x, y;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        x = a;
        y = b;
        case (o)
            2'd0: p = sa * sb;
            2'd1: p = {32'd0, a} * {32'd0, b};
            2'd2: p = {32'(x % y), 32'(x / y)};
            default: p = {b == 0 ? 32'd0 : a % b, b == 0 ? 32'd0 : a / b};
        endcase
        return {1'b0, p};
    endfunction

    always @(posedge clk) begin
        #1;
        if (done) begin
            if (sb_q.size() == 0) check("spurious_done", {63'd0, done}, 64'd0);
            else begin
                logic [64:0] e;
                e = sb_q.pop_front();
                check("res_hi", {32'd0, hi}, {32'd0, e[63:32]});
                check("res_lo", {32'd0, lo}, {32'd0, e[31:0]});
                check("res_dbz", {63'd0, div_by_zero}, {63'd0, e[64]});
            end
        end
    end

    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [64:0] exp, input int exp_len);
        int n;
        sb_q.push_back(exp);
        start = 1'b1;
        op = o;
        operand_a = a;
        operand_b = b;
        n = 0;
        #1;
        while (stall && n < 100) begin
            n++;
            @(negedge clk);
            start = 1'b0;
            #1;
        end
        start = 1'b0;
        check("stall_len", 64'(n), 64'(exp_len));
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        sb_q.delete();
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        op = 2'd0;
        operand_a = '0;
        operand_b = '0;
        wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_dbz", {63'd0, div_by_zero}, 64'd0);
        check("rst_stall", {63'd0, stall}, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        do_op(2'd1, 32'hFFFFFFFF, 32'h2, {1'b0, 32'h1, 32'hFFFFFFFE}, 34);

        // asynchronous reset in the middle of RUN
        @(negedge clk);
        start = 1'b1; op = 2'd1; operand_a = 32'h1234_5678; operand_b = 32'h9;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("mid_busy", {63'd0, busy}, 64'd1);
        rst = 1'b0;
        #1;
        check("arst_hi", {32'd0, hi}, 64'd0);
        check("arst_lo", {32'd0, lo}, 64'd0);
        check("arst_stall", {63'd0, stall}, 64'd0);
        check("arst_busy", {63'd0, busy}, 64'd0);
        #2 rst = 1'b1;
        @(negedge clk);
        do_op(2'd1, 32'hFFFFFFFF, 32'h2, {1'b0, 32'h1, 32'hFFFFFFFE}, 34);

        // back-to-back: second start issued in the DONE cycle
        do_op(2'd0, 32'hFFFFFFFD, 32'd5, {1'b0, 32'hFFFFFFFF, 32'hFFFFFFF1}, 34);
        check("b2b_done", {63'd0, done}, 64'd1);
        do_op(2'd0, 32'd7, 32'hFFFFFFFF, {1'b0, 32'hFFFFFFFF, 32'hFFFFFFF9}, 34);

        do_op(2'd2, 32'hFFFFFFF9, 32'd2, {1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD}, 34);
        do_op(2'd2, 32'h80000000, 32'hFFFFFFFF, {1'b0, 32'h0, 32'h80000000}, 34);
        do_op(2'd3, 32'd100, 32'd7, {1'b0, 32'd2, 32'd14}, 34);

        // flush at RUN cycle 12 with an ignored MTLO earlier in RUN
        @(negedge clk);
        start = 1'b1; op = 2'd2; operand_a = 32'd1000; operand_b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        lo_we = 1'b1; wdata = 32'hCAFE;
        @(negedge clk);
        lo_we = 1'b0;
        repeat (6) @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush_stall_run", {63'd0, stall}, 64'd1);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_stall", {63'd0, stall}, 64'd0);
        check("flush_busy", {63'd0, busy}, 64'd0);
        repeat (40) @(negedge clk);
        check("flush_hi", {32'd0, hi}, 64'd2);
        check("flush_lo", {32'd0, lo}, 64'd14);

        lo_we = 1'b1; wdata = 32'hCAFE;
        @(negedge clk);
        lo_we = 1'b0;
        check("mtlo_idle", {32'd0, lo}, 64'hCAFE);

        hi_we = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h5678;
        @(negedge clk);
        lo_we = 1'b0;
        do_op(2'd3, 32'd55, 32'd0, {1'b1, 32'h1234, 32'h5678}, 1);

        // start with flush in DONE/IDLE is ignored
        start = 1'b1; flush = 1'b1; op = 2'd1; operand_a = 32'd3; operand_b = 32'd3;
        #1;
        check("flush_start_stall", {63'd0, stall}, 64'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1;
        check("flush_start_busy", {63'd0, busy}, 64'd0);

        for (int i = 0; i < 8; i++) begin
            logic [1:0]  o;
            logic [31:0] a, b;
            o = 2'(i);
            a = $urandom;
            b = $urandom | 32'h1;
            @(negedge clk);
            do_op(o, a, b, model(o, a, b), 34);
        end

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
